// File: rtl/bp_pkg.sv
// Package bp_pkg: shared definitions for the btb_predictor branch target buffer.
//   - default configuration widths (the top-level parameters default to these)
//   - btb_entry_t: one BTB entry {valid, tag, target, ctr} at the default widths
//   - sat_inc / sat_dec: saturating step helpers for the direction counters
package bp_pkg;

  localparam int ENTRIES_DEF  = 16;
  localparam int CTR_BITS_DEF = 2;
  localparam int PC_W_DEF     = 32;
  localparam int CNT_W_DEF    = 32;
  localparam int IDX_W_DEF    = $clog2(ENTRIES_DEF);
  localparam int TAG_W_DEF    = PC_W_DEF - IDX_W_DEF - 2;

  typedef struct packed {
    logic                    valid;
    logic [TAG_W_DEF-1:0]    tag;
    logic [PC_W_DEF-1:0]     target;
    logic [CTR_BITS_DEF-1:0] ctr;
  } btb_entry_t;

  // Counters are passed zero-extended to 32 bits so one function pair serves
  // every CTR_BITS setting; callers truncate the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
    return (v >= maxv) ? maxv : v + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return (v == 32'd0) ? 32'd0 : v - 32'd1;
  endfunction

endpackage

// File: rtl/bp_stats.sv
// bp_stats: three saturating event counters for the branch predictor.
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   upd_valid         a resolved branch arrived this cycle
//   mispredict        that branch was mispredicted
//   stat_lookups      non-reset cycles seen
//   stat_branches     resolved branches seen
//   stat_mispredicts  mispredicted branches seen
// All counters stick at all-ones rather than wrapping.
module bp_stats #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             upd_valid,
  input  logic             mispredict,
  output logic [CNT_W-1:0] stat_lookups,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_lookups     <= '0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (!(&stat_lookups))
        stat_lookups <= stat_lookups + 1'b1;
      if (upd_valid && !(&stat_branches))
        stat_branches <= stat_branches + 1'b1;
      if (mispredict && !(&stat_mispredicts))
        stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped branch target buffer with per-entry saturating
// direction counters.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   PC              fetch lookup address (combinational lookup)
//   pred_taken      predicted taken (valid, tag match, counter MSB set)
//   pred_target     predicted target, 0 when not predicted taken
//   upd_*           resolved-branch update from execute/memory
//   flush           invalidate all entries (wins over a same-cycle update)
//   stat_*          event counters, present only when BP_STATS_EN is defined
// Optional feature macro: BP_STATS_EN (adds the bp_stats counters and ports).
module btb_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES  = ENTRIES_DEF,
  parameter int CTR_BITS = CTR_BITS_DEF,
  parameter int PC_W     = PC_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [PC_W-1:0]  PC,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_pred_taken,
  input  logic             flush
`ifdef BP_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_lookups,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - 1'b1;

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [PC_W-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
  } entry_t;

  entry_t tbl [ENTRIES];

  // Lookup side
  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  entry_t           l_ent;

  assign l_idx = PC[IDX_W+1:2];
  assign l_tag = PC[PC_W-1:IDX_W+2];
  assign l_ent = tbl[l_idx];

  // Gated by RST as well so the outputs drop the instant reset rises.
  assign pred_taken  = !RST && l_ent.valid && (l_ent.tag == l_tag) && l_ent.ctr[CTR_BITS-1];
  assign pred_target = pred_taken ? l_ent.target : '0;

  // Update side
  logic [IDX_W-1:0]    u_idx;
  logic [TAG_W-1:0]    u_tag;
  entry_t              u_ent;
  logic                u_hit;
  logic [CTR_BITS-1:0] u_ctr_inc;
  logic [CTR_BITS-1:0] u_ctr_dec;

  assign u_idx     = upd_pc[IDX_W+1:2];
  assign u_tag     = upd_pc[PC_W-1:IDX_W+2];
  assign u_ent     = tbl[u_idx];
  assign u_hit     = u_ent.valid && (u_ent.tag == u_tag);
  assign u_ctr_inc = CTR_BITS'(sat_inc(32'(u_ent.ctr), 32'(CTR_MAX)));
  assign u_ctr_dec = CTR_BITS'(sat_dec(32'(u_ent.ctr)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
    end else if (flush) begin
      // Tags and targets are left as they are; only validity and training reset.
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i].valid <= 1'b0;
        tbl[i].ctr   <= CTR_WNT;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          tbl[u_idx].ctr    <= u_ctr_inc;
          tbl[u_idx].target <= upd_target;
        end else begin
          tbl[u_idx].ctr <= u_ctr_dec;
        end
      end else if (upd_taken) begin
        // Allocate (or evict an aliasing entry) as weakly taken.
        tbl[u_idx] <= '{valid: 1'b1, tag: u_tag, target: upd_target, ctr: CTR_WT};
      end
    end
  end

  logic unused_lsbs;
  assign unused_lsbs = ^{PC[1:0], upd_pc[1:0]};

`ifdef BP_STATS_EN
  logic mispredict;
  assign mispredict = upd_valid && (upd_pred_taken != upd_taken);

  bp_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .CLK              (CLK),
    .RST              (RST),
    .upd_valid        (upd_valid),
    .mispredict       (mispredict),
    .stat_lookups     (stat_lookups),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );
`else
  logic unused_pred_taken;
  assign unused_pred_taken = upd_pred_taken;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking testbench for btb_predictor (default parameters:
// ENTRIES=16, CTR_BITS=2, PC_W=32). With BP_STATS_EN defined the
// statistics counters are exercised as well.
module tb_btb_predictor;

  logic        CLK;
  logic        RST;
  logic [31:0] PC;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic        flush;
`ifdef BP_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int checks   = 0;
  int failures = 0;

  btb_predictor dut (
    .CLK            (CLK),
    .RST            (RST),
    .PC             (PC),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .flush          (flush)
`ifdef BP_STATS_EN
    ,
    .stat_lookups     (stat_lookups),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance past the next rising edge; inputs change and outputs are
  // sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present one resolved branch for a single cycle.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic ptk);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_pred_taken = ptk;
    step();
    upd_valid = 1'b0; upd_taken = 1'b0; upd_pred_taken = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; PC = 32'h40;
    #1;
    checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL reset_hold got=%0b/%h exp=0/00000000", pred_taken, pred_target);
    end
    step();
    RST = 1'b0;
    step();
    #1;
    checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL reset_release got=%0b/%h exp=0/00000000", pred_taken, pred_target);
    end
  endtask

  task automatic test_alloc();
    PC = 32'h40;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
    #1;
    checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL alloc_no_bypass got=%0b/%h exp=0/00000000", pred_taken, pred_target);
    end
    step();
    upd_valid = 1'b0; upd_taken = 1'b0;
    #1;
    checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h100}) begin
      failures++;
      $display("FAIL alloc_hit got=%0b/%h exp=1/00000100", pred_taken, pred_target);
    end
  endtask

  task automatic test_alias();
    PC = 32'h440;
    #1;
    checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL alias_lookup got=%0b/%h exp=0/00000000", pred_taken, pred_target);
    end
    PC = 32'h8000_0040;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL alias_high_tag got=%0b exp=0", pred_taken);
    end
    upd(32'h440, 1'b0, 32'h999, 1'b0);
    PC = 32'h40;
    #1;
    checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h100}) begin
      failures++;
      $display("FAIL alias_nt_keeps got=%0b/%h exp=1/00000100", pred_taken, pred_target);
    end
    PC = 32'h440;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL alias_nt_no_alloc got=%0b exp=0", pred_taken);
    end
  endtask

  task automatic test_other_index();
    upd(32'h44, 1'b1, 32'h300, 1'b0);
    PC = 32'h44;
    #1;
    checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h300}) begin
      failures++;
      $display("FAIL idx1_hit got=%0b/%h exp=1/00000300", pred_taken, pred_target);
    end
    PC = 32'h40;
    #1;
    checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h100}) begin
      failures++;
      $display("FAIL idx0_intact got=%0b/%h exp=1/00000100", pred_taken, pred_target);
    end
  endtask

  // Counter at 0x40 starts at 2; expected predictions per update below.
  task automatic test_hysteresis();
    logic        tk  [11] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0};
    logic [31:0] tg  [11] = '{32'h100, 32'h100, 32'h100, 0, 0, 0, 0,
                              32'h100, 32'h100, 32'h200, 0};
    // resulting ctr:        3  3  3  2  1  0  0  1  2  3  2
    logic        ep  [11] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
    logic [31:0] et  [11] = '{32'h100, 32'h100, 32'h100, 32'h100, 0, 0, 0, 0,
                              32'h100, 32'h200, 32'h200};
    PC = 32'h40;
    for (int i = 0; i < 11; i++) begin
      upd(32'h40, tk[i], tg[i], 1'b0);
      #1;
      checks++;
      if ({pred_taken, pred_target} !== {ep[i], et[i]}) begin
        failures++;
        $display("FAIL hyst_step%0d got=%0b/%h exp=%0b/%h", i, pred_taken, pred_target,
                 ep[i], et[i]);
      end
    end
  endtask

  task automatic test_flush();
    PC = 32'h40;
    flush = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h500;
    #1;
    checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h200}) begin
      failures++;
      $display("FAIL flush_same_cycle got=%0b/%h exp=1/00000200", pred_taken, pred_target);
    end
    step();
    flush = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0;
    #1;
    checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL flush_wins got=%0b/%h exp=0/00000000", pred_taken, pred_target);
    end
    PC = 32'h44;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL flush_all got=%0b exp=0", pred_taken);
    end
    upd(32'h40, 1'b0, 32'h0, 1'b1);
    PC = 32'h40;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL flush_nt_miss got=%0b exp=0", pred_taken);
    end
    upd(32'h40, 1'b1, 32'h600, 1'b0);
    #1;
    checks++;
    if ({pred_taken, pred_target} !== {1'b1, 32'h600}) begin
      failures++;
      $display("FAIL flush_realloc got=%0b/%h exp=1/00000600", pred_taken, pred_target);
    end
  endtask

  task automatic test_async_reset();
    upd(32'h44, 1'b1, 32'h700, 1'b0);
    PC = 32'h40;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h800;
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL rst_immediate got=%0b/%h exp=0/00000000", pred_taken, pred_target);
    end
    step();
    RST = 1'b0; upd_valid = 1'b0; upd_taken = 1'b0;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL rst_clears_40 got=%0b exp=0", pred_taken);
    end
    PC = 32'h44;
    #1;
    checks++;
    if (pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL rst_clears_44 got=%0b exp=0", pred_taken);
    end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    RST = 1'b1;
    step();
    RST = 1'b0;
    // 10 counted edges: 4 updates, the third one mispredicted.
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    step();
    upd(32'h48, 1'b0, 32'h0, 1'b0);
    step();
    step();
    upd(32'h4c, 1'b1, 32'h120, 1'b0);
    step();
    upd(32'h40, 1'b1, 32'h100, 1'b1);
    step();
    step();
    checks++;
    if ({stat_lookups, stat_branches, stat_mispredicts} !== {32'd10, 32'd4, 32'd1}) begin
      failures++;
      $display("FAIL stats_counts got=%0d/%0d/%0d exp=10/4/1", stat_lookups, stat_branches,
               stat_mispredicts);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if ({stat_lookups, stat_branches} !== {32'd11, 32'd4}) begin
      failures++;
      $display("FAIL stats_flush_keeps got=%0d/%0d exp=11/4", stat_lookups, stat_branches);
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({stat_lookups, stat_branches, stat_mispredicts} !== 96'd0) begin
      failures++;
      $display("FAIL stats_reset got=%0d/%0d/%0d exp=0/0/0", stat_lookups, stat_branches,
               stat_mispredicts);
    end
    step();
    RST = 1'b0;
  endtask
`endif

  initial begin
    RST = 1'b1; PC = '0; flush = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;
    test_reset();
    test_alloc();
    test_alias();
    test_other_index();
    test_hysteresis();
    test_flush();
    test_async_reset();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Parametrised direct-mapped branch target buffer with per-entry N-bit saturating direction counters; the next-generation fetch-stage predictor for the pipeline. The block performs a combinational lookup on the fetch PC, producing a taken prediction and target. It is updated from execute/memory with resolved branch outcomes. Compared to the fixed four-entry predictor, it adds configurable depth and counter width, tag-qualified counter training, a flush, and optional statistics counters.

## Interface
- ENTRIES, 16, number of BTB entries; power of two, ≥2; IDX_W = $clog2(ENTRIES)
- CTR_BITS, 2, direction counter width, ≥1
- PC_W, 32, PC/target width; TAG_W = PC_W − IDX_W − 2
- CNT_W, 32, statistics counter width (only with BP_STATS_EN)

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- PC  in  PC_W  fetch-stage lookup address
- pred_taken  out  1  predict taken this cycle
- pred_target  out  PC_W  predicted target; 0 when pred_taken=0
- upd_valid  in  1  resolved branch present this cycle
- upd_pc  in  PC_W  PC of resolved branch
- upd_taken  in  1  resolved direction
- upd_target  in  PC_W  resolved target address
- upd_pred_taken  in  1  prediction that was made for this branch at fetch
- flush  in  1  invalidate all entries
- stat_lookups, stat_branches, stat_mispredicts  out  CNT_W each  (BP_STATS_EN only)

## Operation
- Index = PC[IDX_W+1:2]; tag = PC[PC_W−1:IDX_W+2]. Entry = {valid, tag, target, ctr}.
- Lookup: pred_taken=1 iff entry valid, tag match, ctr MSB=1; pred_target=entry.target then, else 0.
- Update (upd_valid=1), indexed by upd_pc:
  - Hit (valid and tag match): taken → ctr+1 saturating at 2^CTR_BITS−1, target ← upd_target; not taken → ctr−1 saturating at 0; the entry stays valid.
  - Miss, taken: allocate/replace: valid=1, tag, target ← upd_target, ctr=2^(CTR_BITS−1) (weakly taken).
  - Miss, not taken: no state change.
- Mispredict = upd_valid && (upd_pred_taken != upd_taken).
- Flush: all valid ← 0, all ctr ← 2^(CTR_BITS−1)−1 (weakly not taken); tags/targets untouched. Flush wins over a same-cycle update.
- CTR_BITS=1: ctr is a last-outcome bit; allocation sets it to 1.

## Timing
- Lookup is purely combinational, same cycle as PC.
- Update/flush are committed on the rising CLK edge; they are visible to lookups from the next cycle.
- Same-cycle lookup and update to the same index: the lookup returns pre-update state. There is no bypass.
- Back-to-back updates to the same index: each applies to the result of the previous one.
- RST (any time, including mid-update): all valid=0, ctr=2^(CTR_BITS−1)−1, tag=0, target=0, stats=0. Outputs go to pred_taken=0 and pred_target=0 immediately while RST is high.

## Configuration
- BP_STATS_EN defined:
  - stat_lookups increments every non-reset cycle.
  - stat_branches increments on upd_valid.
  - stat_mispredicts increments on mispredict.
  - All three saturate at 2^CNT_W−1 and are not cleared by flush.
- BP_STATS_EN undefined: the stat ports and their counters are absent. Prediction behaviour is identical.

## Structure
- Package bp_pkg: the btb_entry_t struct (valid, tag, target, ctr), parameterised widths via localparams, and a sat_inc/sat_dec function pair.
- Sub-module bp_stats: the three saturating counters, instantiated only under BP_STATS_EN.

## Test plan
- After RST, lookup of PC=0x0000_0040 → pred_taken=0, pred_target=0.
- Update upd_pc=0x40, taken, target=0x100. The next cycle, lookup 0x40 → pred_taken=1, pred_target=0x100 (ctr=2).
- Aliasing: after the previous case, lookup PC=0x440 (same index, different tag) → pred_taken=0. A not-taken update at 0x440 leaves the 0x40 entry intact.
- Saturation/hysteresis: 0x40 taken ×3 → ctr=3. One not-taken → ctr=2, still predicted taken. Second not-taken → ctr=1, pred_taken=0.
- Same-cycle flush and update at 0x40 → entry invalid next cycle, pred_taken=0. Same-cycle lookup during the update returns the old prediction.
- BP_STATS_EN: 10 cycles with 4 updates, 1 having upd_pred_taken≠upd_taken → stat_lookups=10, stat_branches=4, stat_mispredicts=1. Assert RST mid-run → all stats return to 0.
